constraint_loader: RTL and testbench
====================================

CONSTRAINT_LOADER -- requirements
Module: constraint_loader

Interface
REQ-001 The block SHALL have parameter ROWS, default 70, meaning the number of constraint rows per frame.
REQ-002 The block SHALL have parameter ROW_BYTES, default 15, meaning the bytes per 120-bit row.
REQ-003 The block SHALL have parameter HDR, default 8'hA5, meaning the frame start byte.
REQ-004 The block SHALL have port clock, input, 1 bit: the system clock.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port byte_in, input, 8 bits: the incoming payload byte.
REQ-007 The block SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-008 The block SHALL have port byte_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-009 The block SHALL have port start_sending_constraint, output, 1 bit: row strobe to the display.
REQ-010 The block SHALL have port constraint_vals, output, 120 bits: the current row, with bit 119 as the leftmost cell.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a frame is being loaded or streamed.
REQ-012 The block SHALL have port done, output, 1 bit: a 1-cycle pulse after a frame has been streamed.
REQ-013 The block SHALL have port frame_error, output, 1 bit: a 1-cycle pulse on a checksum mismatch.

Function
REQ-014 The block SHALL implement FSM states WAIT_HDR, LOAD, CHECK, PREFETCH, STREAM and FINISH.
REQ-015 A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both high.
REQ-016 byte_ready SHALL be high in WAIT_HDR, LOAD and CHECK, and low in all other states.
REQ-017 In WAIT_HDR, an accepted byte equal to HDR SHALL move the FSM to LOAD and clear the byte counter, row counter and checksum; any other accepted byte SHALL be discarded.
REQ-018 In LOAD, bytes SHALL be packed MSB-first: row byte 0 goes to bits 119:112 and row byte 14 goes to bits 7:0.
REQ-019 On acceptance of byte ROW_BYTES-1, the packed row SHALL be written to row-RAM address row_cnt in the same cycle.
REQ-020 On acceptance of byte ROW_BYTES-1, the byte counter SHALL wrap to 0 and row_cnt SHALL increment.
REQ-021 The running checksum SHALL be the XOR of all accepted payload bytes; HDR and the checksum byte are excluded.
REQ-022 After row ROWS-1 has been written, the FSM SHALL enter CHECK.
REQ-023 In CHECK, an accepted byte equal to the checksum SHALL move the FSM to PREFETCH.
REQ-024 In CHECK, an accepted byte not equal to the checksum SHALL pulse frame_error for 1 cycle, leave the FSM in WAIT_HDR, and produce no strobe.
REQ-025 In PREFETCH, the block SHALL issue a read of address 0, which has 1-cycle RAM latency.
REQ-026 In STREAM, start_sending_constraint SHALL be high for exactly ROWS consecutive cycles.
REQ-027 In strobe cycle k, constraint_vals SHALL equal row k, for k from 0 to ROWS-1.
REQ-028 Relative to checksum acceptance at edge N, the first strobe SHALL appear after edge N+2 and the last after edge N+ROWS+1.
REQ-029 constraint_vals SHALL be registered, and SHALL be 0 whenever the strobe is low.
REQ-030 FINISH SHALL pulse done for 1 cycle, then return to WAIT_HDR.
REQ-031 HDR bytes received during LOAD or CHECK SHALL be treated as data; there is no resynchronisation inside a frame.
REQ-032 byte_valid during PREFETCH, STREAM or FINISH SHALL be ignored, with no byte consumed.
REQ-033 busy SHALL be high in every state except WAIT_HDR.

Reset
REQ-034 While reset is high at an edge, the FSM SHALL return to WAIT_HDR and all counters and the checksum SHALL be cleared.
REQ-035 While reset is high at an edge, byte_ready SHALL be 0 and start_sending_constraint, constraint_vals, busy, done and frame_error SHALL be 0.
REQ-036 A reset asserted mid-LOAD or mid-STREAM SHALL abort the frame immediately, with no further strobes.
REQ-037 The row-RAM contents SHALL not be cleared by reset.
REQ-038 byte_ready SHALL go high in the first cycle after reset deasserts.

Structure
REQ-039 ROWS, ROW_BYTES, HDR, ROW_W=120 and the FSM state enum SHALL live in the shared package nonogram_pkg.
REQ-040 The row storage SHALL be a sub-module constraint_row_ram: ROWS x 120 bits, single write port, single read port, registered read with 1-cycle latency, inferred as BRAM.

Verification
REQ-041 Send A5, then rows with row k = {15{k[7:0]}}, then the correct XOR -> 70 contiguous strobes, row k value matches, done one cycle after the last strobe.
REQ-042 Send a valid frame with the checksum byte XORed with 01 -> one frame_error pulse, zero strobes, byte_ready high again, and a following valid frame streams normally.
REQ-043 Send 00, 3C, then A5 plus a frame -> the leading bytes are discarded and the stream is correct.
REQ-044 Assert reset after 500 payload bytes, then send a full frame -> no strobes before that frame completes, then correct rows.
REQ-045 Toggle byte_valid randomly at 30% duty through a frame -> identical stream to REQ-041, and no bytes are accepted during the strobe cycles.
REQ-046 Send a frame in which row 0 contains byte A5 -> it is stored as data, with constraint_vals bits 119:112 = A5 on strobe 0.

Source files
------------

// File: rtl/nonogram_pkg.sv
// Shared constants and FSM state type for the nonogram constraint path.
// Frame layout: HDR, then ROWS rows of ROW_BYTES bytes, then one XOR checksum byte.
package nonogram_pkg;

    localparam int          ROWS      = 70;
    localparam int          ROW_BYTES = 15;
    localparam logic [7:0]  HDR       = 8'hA5;
    localparam int          ROW_W     = 120;

    typedef enum logic [2:0] {
        WAIT_HDR,
        LOAD,
        CHECK,
        PREFETCH,
        STREAM,
        FINISH
    } loader_state_t;

endpackage

// File: rtl/constraint_row_ram.sv
// Simple dual-port row store: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module constraint_row_ram #(
    parameter int DEPTH = 70,
    parameter int WIDTH = 120,
    parameter int AW    = 7
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/constraint_loader.sv
// Receives a framed byte stream of constraint rows, verifies its XOR checksum,
// then replays the stored rows to the display as ROWS back-to-back strobes.
module constraint_loader #(
    parameter int         ROWS      = nonogram_pkg::ROWS,
    parameter int         ROW_BYTES = nonogram_pkg::ROW_BYTES,
    parameter logic [7:0] HDR       = nonogram_pkg::HDR
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [7:0]                     byte_in,
    input  logic                           byte_valid,
    output logic                           byte_ready,
    output logic                           start_sending_constraint,
    output logic [nonogram_pkg::ROW_W-1:0] constraint_vals,
    output logic                           busy,
    output logic                           done,
    output logic                           frame_error
);

    import nonogram_pkg::*;

    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BW = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;

    loader_state_t    state;
    loader_state_t    next_state;
    logic [BW-1:0]    byte_cnt;
    logic [AW-1:0]    row_cnt;
    logic [AW-1:0]    stream_cnt;
    logic [7:0]       checksum;
    logic [ROW_W-1:0] row_buf;
    logic [ROW_W-1:0] wr_data;
    logic [ROW_W-1:0] rd_data;
    logic [AW-1:0]    rd_addr;
    logic             wr_en;
    logic             rd_en;
    logic             accept;
    logic             last_byte;
    logic             last_row;
    logic             last_stream;

    assign accept      = byte_valid && byte_ready;
    assign last_byte   = (byte_cnt == BW'(ROW_BYTES - 1));
    assign last_row    = (row_cnt == AW'(ROWS - 1));
    assign last_stream = (stream_cnt == AW'(ROWS - 1));
    assign wr_data     = {row_buf[ROW_W-9:0], byte_in};

    always_ff @(posedge clock) begin
        if (reset)
            state <= WAIT_HDR;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_HDR: if (accept && byte_in == HDR) next_state = LOAD;
            LOAD:     if (accept && last_byte && last_row) next_state = CHECK;
            CHECK:    if (accept) next_state = (byte_in == checksum) ? PREFETCH : WAIT_HDR;
            PREFETCH: next_state = STREAM;
            STREAM:   if (last_stream) next_state = FINISH;
            FINISH:   next_state = WAIT_HDR;
            default:  next_state = WAIT_HDR;
        endcase
    end

    // While streaming, the RAM is always read one row ahead of the strobe.
    always_comb begin
        byte_ready = !reset && (state == WAIT_HDR || state == LOAD || state == CHECK);
        busy       = (state != WAIT_HDR);
        wr_en      = (state == LOAD) && accept && last_byte;
        rd_en      = 1'b0;
        rd_addr    = '0;
        if (state == PREFETCH) begin
            rd_en = 1'b1;
        end else if (state == STREAM && !last_stream) begin
            rd_en   = 1'b1;
            rd_addr = stream_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt                 <= '0;
            row_cnt                  <= '0;
            stream_cnt               <= '0;
            checksum                 <= '0;
            row_buf                  <= '0;
            start_sending_constraint <= 1'b0;
            constraint_vals          <= '0;
            done                     <= 1'b0;
            frame_error              <= 1'b0;
        end else begin
            start_sending_constraint <= 1'b0;
            constraint_vals          <= '0;
            done                     <= 1'b0;
            frame_error              <= 1'b0;
            case (state)
                WAIT_HDR: begin
                    if (accept && byte_in == HDR) begin
                        byte_cnt <= '0;
                        row_cnt  <= '0;
                        checksum <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        row_buf  <= wr_data;
                        checksum <= checksum ^ byte_in;
                        if (last_byte) begin
                            byte_cnt <= '0;
                            row_cnt  <= row_cnt + 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (accept && byte_in != checksum)
                        frame_error <= 1'b1;
                end
                PREFETCH: stream_cnt <= '0;
                STREAM: begin
                    start_sending_constraint <= 1'b1;
                    constraint_vals          <= rd_data;
                    stream_cnt               <= stream_cnt + 1'b1;
                end
                FINISH: done <= 1'b1;
                default: ;
            endcase
        end
    end

    constraint_row_ram #(
        .DEPTH (ROWS),
        .WIDTH (ROW_W),
        .AW    (AW)
    ) u_row_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (row_cnt),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_constraint_loader.sv
// Directed bench for constraint_loader: frame load, checksum handling, streaming
// timing, reset aborts and sparse byte_valid.
module tb_constraint_loader;

    localparam int NROWS = 70;
    localparam int NBYTES = 15;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         start_sending_constraint;
    logic [119:0] constraint_vals;
    logic         busy;
    logic         done;
    logic         frame_error;

    int checks = 0;
    int passes = 0;
    int strobe_total = 0;
    logic [119:0] exp_rows [NROWS];

    constraint_loader dut (
        .clock                    (clock),
        .reset                    (reset),
        .byte_in                  (byte_in),
        .byte_valid               (byte_valid),
        .byte_ready               (byte_ready),
        .start_sending_constraint (start_sending_constraint),
        .constraint_vals          (constraint_vals),
        .busy                     (busy),
        .done                     (done),
        .frame_error              (frame_error)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (start_sending_constraint === 1'b1) strobe_total++;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // mode 0: row k = {15{k}}, mode 1: same with A5 planted in data, mode 2: mixed pattern
    task automatic fill_rows(input int mode);
        for (int k = 0; k < NROWS; k++)
            for (int j = 0; j < NBYTES; j++)
                exp_rows[k][119-8*j -: 8] = (mode == 2) ? 8'((k * 3 + j * 17) ^ 8'h5A) : 8'(k);
        if (mode == 1) begin
            exp_rows[0][119:112] = 8'hA5;
            exp_rows[5][95:88]   = 8'hA5;
        end
    endtask

    function automatic logic [7:0] frame_xor();
        logic [7:0] x = 8'h00;
        for (int k = 0; k < NROWS; k++)
            for (int j = 0; j < NBYTES; j++)
                x ^= exp_rows[k][119-8*j -: 8];
        return x;
    endfunction

    // Entered and left on a negedge; returns on the negedge right after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit sparse);
        int guard = 0;
        if (sparse)
            while ($urandom_range(0, 99) >= 30) @(negedge clock);
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            $display("[TB] FAIL send_byte: byte_ready=%b, required 1", byte_ready);
        end
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input bit bad, input bit sparse);
        logic [7:0] cks = frame_xor();
        send_byte(8'hA5, sparse);
        for (int k = 0; k < NROWS; k++)
            for (int j = 0; j < NBYTES; j++)
                send_byte(exp_rows[k][119-8*j -: 8], sparse);
        send_byte(bad ? (cks ^ 8'h01) : cks, sparse);
    endtask

    // Starts on the negedge after checksum acceptance (edge N).
    task automatic check_stream(input string tag, input bit noise);
        logic early;
        early = start_sending_constraint;
        @(negedge clock);
        early = early | start_sending_constraint;
        checks++;
        if (early !== 1'b0)
            $display("[TB] FAIL %s first_strobe_early: strobe=%b, required 0", tag, early);
        else passes++;
        for (int k = 0; k < NROWS; k++) begin
            if (noise) begin
                byte_in    = 8'h3C;
                byte_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
            checks++;
            if (start_sending_constraint !== 1'b1 || constraint_vals !== exp_rows[k] ||
                (noise && byte_ready !== 1'b0))
                $display("[TB] FAIL %s row%0d: strobe=%b ready=%b vals=%h, required strobe=1 ready=0 vals=%h",
                         tag, k, start_sending_constraint, byte_ready, constraint_vals, exp_rows[k]);
            else passes++;
        end
        byte_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (start_sending_constraint !== 1'b0 || constraint_vals !== 120'd0 || done !== 1'b1)
            $display("[TB] FAIL %s done_cycle: strobe=%b vals=%h done=%b, required 0/0/1",
                     tag, start_sending_constraint, constraint_vals, done);
        else passes++;
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b1)
            $display("[TB] FAIL %s after_done: done=%b busy=%b ready=%b, required 0/0/1",
                     tag, done, busy, byte_ready);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || frame_error !== 1'b0)
            $display("[TB] FAIL reset_ctrl: ready=%b busy=%b done=%b ferr=%b, required 0000",
                     byte_ready, busy, done, frame_error);
        else passes++;
        checks++;
        if (start_sending_constraint !== 1'b0 || constraint_vals !== 120'd0)
            $display("[TB] FAIL reset_stream: strobe=%b vals=%h, required 0/0",
                     start_sending_constraint, constraint_vals);
        else passes++;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (byte_ready !== 1'b1)
            $display("[TB] FAIL reset_release: byte_ready=%b, required 1", byte_ready);
        else passes++;
    endtask

    task automatic test_basic_frame();
        fill_rows(0);
        send_frame(1'b0, 1'b0);
        check_stream("basic", 1'b0);
    endtask

    task automatic test_bad_checksum();
        int base;
        fill_rows(0);
        send_frame(1'b1, 1'b0);
        base = strobe_total;
        checks++;
        if (frame_error !== 1'b1 || byte_ready !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL bad_cks_pulse: ferr=%b ready=%b busy=%b, required 1/1/0",
                     frame_error, byte_ready, busy);
        else passes++;
        @(negedge clock);
        checks++;
        if (frame_error !== 1'b0)
            $display("[TB] FAIL bad_cks_width: frame_error=%b, required 0", frame_error);
        else passes++;
        repeat (80) @(negedge clock);
        checks++;
        if (strobe_total !== base)
            $display("[TB] FAIL bad_cks_strobes: strobes=%0d, required 0", strobe_total - base);
        else passes++;
        send_frame(1'b0, 1'b0);
        check_stream("after_bad", 1'b0);
    endtask

    task automatic test_leading_garbage();
        fill_rows(2);
        send_byte(8'h00, 1'b0);
        send_byte(8'h3C, 1'b0);
        checks++;
        if (busy !== 1'b0)
            $display("[TB] FAIL garbage_busy: busy=%b, required 0", busy);
        else passes++;
        send_frame(1'b0, 1'b0);
        check_stream("garbage", 1'b0);
    endtask

    task automatic test_reset_abort();
        int base;
        fill_rows(0);
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 500; i++)
            send_byte(exp_rows[i / NBYTES][119-8*(i % NBYTES) -: 8], 1'b0);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || byte_ready !== 1'b0)
            $display("[TB] FAIL load_abort: busy=%b ready=%b, required 0/0", busy, byte_ready);
        else passes++;
        reset = 1'b0;
        @(negedge clock);
        base = strobe_total;
        fill_rows(2);
        send_frame(1'b0, 1'b0);
        checks++;
        if (strobe_total !== base)
            $display("[TB] FAIL load_abort_strobes: strobes=%0d, required 0", strobe_total - base);
        else passes++;
        check_stream("post_abort", 1'b0);
        send_frame(1'b0, 1'b0);
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        base = strobe_total;
        repeat (80) @(negedge clock);
        checks++;
        if (strobe_total !== base || constraint_vals !== 120'd0 || busy !== 1'b0)
            $display("[TB] FAIL stream_abort: strobes=%0d vals=%h busy=%b, required 0/0/0",
                     strobe_total - base, constraint_vals, busy);
        else passes++;
    endtask

    task automatic test_sparse_valid();
        fill_rows(0);
        send_frame(1'b0, 1'b1);
        check_stream("sparse", 1'b1);
    endtask

    task automatic test_hdr_in_data();
        fill_rows(1);
        send_frame(1'b0, 1'b0);
        check_stream("hdr_data", 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        test_reset();
        test_basic_frame();
        test_bad_checksum();
        test_leading_garbage();
        test_reset_abort();
        test_sparse_valid();
        test_hdr_in_data();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
